time_alarm_keeper: RTL and testbench
====================================

TIME_ALARM_KEEPER -- requirements
Module: time_alarm_keeper

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100000000, meaning clk cycles per second.
REQ-002 SHALL have parameter RING_SECS, default 60, meaning maximum ringing duration in seconds.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port run_en  input  1  1 = timekeeping advances; 0 = paused (adjust mode active).
REQ-006 SHALL have port load  input  1  one-cycle strobe, commit adjusted values.
REQ-007 SHALL have port adjusted  input  2  bit0 = time edited, bit1 = alarm edited.
REQ-008 SHALL have ports time_hours_in, alarm_hours_in  input  5 each; time_minutes_in, alarm_minutes_in  input  6 each; binary values from the adjust block.
REQ-009 SHALL have port alarm_arm  input  1  level, alarm enabled.
REQ-010 SHALL have port alarm_stop  input  1  one-cycle debounced button pulse.
REQ-011 SHALL have ports time_hours  output  5; time_minutes, time_seconds  output  6; running time, binary.
REQ-012 SHALL have ports alarm_hours  output  5; alarm_minutes  output  6; stored alarm, fed back to the adjust block as its preload.
REQ-013 SHALL have port ringing  output  1  alarm sounding.
REQ-014 SHALL have port alarm_led  output  1  blinks at 1 Hz, 50% duty, while ringing.
REQ-015 SHALL have port sec_tick  output  1  one-cycle pulse per elapsed second.

Function
REQ-016 Prescaler SHALL count 0..TICKS_PER_SEC-1 while run_en=1, hold while run_en=0, and assert sec_tick in the cycle it wraps.
REQ-017 On sec_tick, seconds SHALL increment 0..59; wrap carries to minutes 0..59; minute wrap carries to hours 0..23; 23:59:59 SHALL advance to 00:00:00.
REQ-018 load=1 with adjusted[0]=1 SHALL copy time_*_in into hours/minutes, clear seconds and prescaler to 0 in the same edge; load has priority over a coincident tick.
REQ-019 load=1 with adjusted[1]=1 SHALL copy alarm_*_in into the alarm registers.
REQ-020 A load field with hours>23 or minutes>59 SHALL be ignored; that register pair keeps its prior value.
REQ-021 load=1 with adjusted=2'b00 SHALL change nothing.
REQ-022 Alarm FSM states SHALL be IDLE, RINGING, SILENCED; ringing=1 only in RINGING.
REQ-023 IDLE->RINGING SHALL occur on the edge after time equals alarm with seconds=0 and alarm_arm=1 and run_en=1.
REQ-024 RINGING->SILENCED SHALL occur on alarm_stop=1, on alarm_arm=0, or after RING_SECS sec_ticks in RINGING.
REQ-025 SILENCED->IDLE SHALL occur once time hours/minutes no longer equal alarm; prevents re-trigger within the matched minute.
REQ-026 Any load with adjusted[1]=1 SHALL force the FSM to IDLE; a load with adjusted[0]=1 while RINGING SHALL force SILENCED.
REQ-027 alarm_led SHALL equal ringing AND (prescaler < TICKS_PER_SEC/2).
REQ-028 run_en=0 SHALL freeze the ring-duration counter but not block alarm_stop.

Reset
REQ-029 reset=0 SHALL asynchronously force time 00:00:00, alarm 00:00, prescaler 0, ring counter 0, FSM IDLE; ringing, alarm_led, sec_tick 0.
REQ-030 Reset assertion mid-ring SHALL clear ringing without waiting for a clock edge; deassertion is synchronised externally.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2 bits), MAX_HOURS=23, MAX_MINUTES=59, MAX_SECONDS=59, and field widths 5/6.
REQ-032 One sub-module, tick_prescaler (parameterised divider emitting the tick and half-period flag), SHALL be used; counters and FSM stay in the top.

Verification (TICKS_PER_SEC=4, RING_SECS=5)
REQ-033 Load time 23:59 via adjusted=01, run 60 s -> time reads 23:59:59 then 00:00:00 on the next sec_tick.
REQ-034 Load time 06:59, alarm 07:00 (adjusted=11), arm=1 -> ringing rises on the edge after 07:00:00; alarm_led toggles every 2 cycles.
REQ-035 While ringing pulse alarm_stop -> ringing=0 next edge; no re-ring through 07:00:59; re-arms from 07:01:00.
REQ-036 No stop while ringing -> ringing falls after 5 sec_ticks; FSM SILENCED.
REQ-037 load with time_hours_in=24, adjusted=01 -> time unchanged; load and sec_tick same cycle -> seconds=0.
REQ-038 Assert reset mid-ring with clk stopped -> ringing=0 and all outputs at reset values immediately.

Source files
------------

// File: rtl/time_alarm_keeper_pkg.sv
// Shared definitions for the alarm clock: field widths, time limits and the alarm FSM encoding.
package time_alarm_keeper_pkg;

    localparam int HOURS_W = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;

    localparam logic [HOURS_W-1:0] MAX_HOURS   = 5'd23;
    localparam logic [MIN_W-1:0]   MAX_MINUTES = 6'd59;
    localparam logic [SEC_W-1:0]   MAX_SECONDS = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_RINGING  = 2'b01,
        ST_SILENCED = 2'b10
    } alarm_state_e;

    // A loaded hours/minutes pair is only accepted when both fields are in range.
    function automatic logic hm_valid(input logic [HOURS_W-1:0] h, input logic [MIN_W-1:0] m);
        return (h <= MAX_HOURS) && (m <= MAX_MINUTES);
    endfunction

endpackage

// File: rtl/time_alarm_keeper_tick_prescaler.sv
// Divides clk down to a one-cycle tick per second and flags the first half of each second.
module tick_prescaler #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run_en,
    input  logic clear,
    output logic tick,
    output logic first_half
);

    localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(TICKS_PER_SEC / 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A clear (time load) wins over counting so the new second starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run_en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick       = run_en && (cnt_q == LAST);
    assign first_half = (cnt_q < HALF);

endmodule

// File: rtl/time_alarm_keeper.sv
// Alarm clock core: HH:MM:SS timekeeping, adjustable alarm registers and the ring/silence FSM.
module time_alarm_keeper
    import time_alarm_keeper_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int RING_SECS     = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_en,
    input  logic       load,
    input  logic [1:0] adjusted,
    input  logic [4:0] time_hours_in,
    input  logic [5:0] time_minutes_in,
    input  logic [4:0] alarm_hours_in,
    input  logic [5:0] alarm_minutes_in,
    input  logic       alarm_arm,
    input  logic       alarm_stop,
    output logic [4:0] time_hours,
    output logic [5:0] time_minutes,
    output logic [5:0] time_seconds,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic       ringing,
    output logic       alarm_led,
    output logic       sec_tick
);

    localparam int RING_W = (RING_SECS > 1) ? $clog2(RING_SECS + 1) : 1;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);

    logic tick;
    logic first_half;
    logic load_time;
    logic load_alarm;
    logic time_commit;
    logic alarm_commit;
    logic time_match;

    logic [HOURS_W-1:0] hours_q, hours_d;
    logic [MIN_W-1:0]   minutes_q, minutes_d;
    logic [SEC_W-1:0]   seconds_q, seconds_d;
    logic [HOURS_W-1:0] al_hours_q, al_hours_d;
    logic [MIN_W-1:0]   al_minutes_q, al_minutes_d;
    logic [RING_W-1:0]  ring_cnt_q, ring_cnt_d;
    alarm_state_e       state_q, state_d;

    assign load_time    = load && adjusted[0];
    assign load_alarm   = load && adjusted[1];
    assign time_commit  = load_time && hm_valid(time_hours_in, time_minutes_in);
    assign alarm_commit = load_alarm && hm_valid(alarm_hours_in, alarm_minutes_in);
    assign time_match   = (hours_q == al_hours_q) && (minutes_q == al_minutes_q);

    tick_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_prescaler (
        .clk       (clk),
        .reset     (reset),
        .run_en    (run_en),
        .clear     (time_commit),
        .tick      (tick),
        .first_half(first_half)
    );

    // Timekeeping; an accepted time load overrides a tick landing on the same edge.
    always_comb begin
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        if (time_commit) begin
            hours_d   = time_hours_in;
            minutes_d = time_minutes_in;
            seconds_d = '0;
        end else if (tick) begin
            if (seconds_q == MAX_SECONDS) begin
                seconds_d = '0;
                if (minutes_q == MAX_MINUTES) begin
                    minutes_d = '0;
                    hours_d   = (hours_q == MAX_HOURS) ? '0 : hours_q + 5'd1;
                end else begin
                    minutes_d = minutes_q + 6'd1;
                end
            end else begin
                seconds_d = seconds_q + 6'd1;
            end
        end
    end

    always_comb begin
        al_hours_d   = al_hours_q;
        al_minutes_d = al_minutes_q;
        if (alarm_commit) begin
            al_hours_d   = alarm_hours_in;
            al_minutes_d = alarm_minutes_in;
        end
    end

    // Ring duration only advances on seconds spent ringing; tick is already gated by run_en.
    always_comb begin
        ring_cnt_d = '0;
        if (state_q == ST_RINGING) begin
            ring_cnt_d = tick ? ring_cnt_q + RING_W'(1) : ring_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hours_q      <= '0;
            minutes_q    <= '0;
            seconds_q    <= '0;
            al_hours_q   <= '0;
            al_minutes_q <= '0;
            ring_cnt_q   <= '0;
        end else begin
            hours_q      <= hours_d;
            minutes_q    <= minutes_d;
            seconds_q    <= seconds_d;
            al_hours_q   <= al_hours_d;
            al_minutes_q <= al_minutes_d;
            ring_cnt_q   <= ring_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // SILENCED holds until the matched minute passes, so the alarm cannot re-trigger inside it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (time_match && (seconds_q == '0) && alarm_arm && run_en) begin
                    state_d = ST_RINGING;
                end
            end
            ST_RINGING: begin
                if (alarm_stop || !alarm_arm || (tick && (ring_cnt_q == RING_LAST))) begin
                    state_d = ST_SILENCED;
                end
            end
            ST_SILENCED: begin
                if (!time_match) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load_alarm) begin
            state_d = ST_IDLE;
        end else if (load_time && (state_q == ST_RINGING)) begin
            state_d = ST_SILENCED;
        end
    end

    always_comb begin
        ringing   = (state_q == ST_RINGING);
        alarm_led = ringing && first_half;
        sec_tick  = tick;
    end

    assign time_hours    = hours_q;
    assign time_minutes  = minutes_q;
    assign time_seconds  = seconds_q;
    assign alarm_hours   = al_hours_q;
    assign alarm_minutes = al_minutes_q;

endmodule

// File: tb/tb_time_alarm_keeper.sv
// Directed scoreboard bench for time_alarm_keeper with a 4-cycle second and 5-second ring limit.
module tb_time_alarm_keeper;

    localparam int TPS = 4;
    localparam int RS  = 5;

    logic       clk    = 1'b0;
    logic       clk_en = 1'b1;
    logic       reset;
    logic       run_en;
    logic       load;
    logic [1:0] adjusted;
    logic [4:0] time_hours_in;
    logic [5:0] time_minutes_in;
    logic [4:0] alarm_hours_in;
    logic [5:0] alarm_minutes_in;
    logic       alarm_arm;
    logic       alarm_stop;
    logic [4:0] time_hours;
    logic [5:0] time_minutes;
    logic [5:0] time_seconds;
    logic [4:0] alarm_hours;
    logic [5:0] alarm_minutes;
    logic       ringing;
    logic       alarm_led;
    logic       sec_tick;

    time_alarm_keeper #(
        .TICKS_PER_SEC(TPS),
        .RING_SECS    (RS)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .run_en          (run_en),
        .load            (load),
        .adjusted        (adjusted),
        .time_hours_in   (time_hours_in),
        .time_minutes_in (time_minutes_in),
        .alarm_hours_in  (alarm_hours_in),
        .alarm_minutes_in(alarm_minutes_in),
        .alarm_arm       (alarm_arm),
        .alarm_stop      (alarm_stop),
        .time_hours      (time_hours),
        .time_minutes    (time_minutes),
        .time_seconds    (time_seconds),
        .alarm_hours     (alarm_hours),
        .alarm_minutes   (alarm_minutes),
        .ringing         (ringing),
        .alarm_led       (alarm_led),
        .sec_tick        (sec_tick)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    event chk_ev;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        return 32'(h * 4096 + m * 64 + s);
    endfunction

    function automatic logic [31:0] hm(input int h, input int m);
        return 32'(h * 64 + m);
    endfunction

    function automatic logic [31:0] get_sig(input int sel);
        case (sel)
            0:       return {15'd0, time_hours, time_minutes, time_seconds};
            1:       return {21'd0, alarm_hours, alarm_minutes};
            2:       return {31'd0, ringing};
            3:       return {31'd0, alarm_led};
            default: return {31'd0, sec_tick};
        endcase
    endfunction

    // Monitor: compares every expectation due by the current cycle at the falling edge.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk or chk_ev);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e   = sb_q.pop_front();
                act = get_sig(e.sel);
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_sig(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.exp  = v;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic cyc_step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [1:0] adj, input logic [4:0] th, input logic [5:0] tm,
                           input logic [4:0] ah, input logic [5:0] am);
        adjusted         = adj;
        time_hours_in    = th;
        time_minutes_in  = tm;
        alarm_hours_in   = ah;
        alarm_minutes_in = am;
        load             = 1'b1;
        cyc_step(1);
        load     = 1'b0;
        adjusted = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; run_en = 1'b0; load = 1'b0; adjusted = 2'b00;
        time_hours_in = '0; time_minutes_in = '0; alarm_hours_in = '0; alarm_minutes_in = '0;
        alarm_arm = 1'b0; alarm_stop = 1'b0;

        cyc_step(2);
        expect_sig("reset_time", 0, hms(0, 0, 0));
        expect_sig("reset_alarm", 1, hm(0, 0));
        expect_sig("reset_ringing", 2, 0);
        expect_sig("reset_led", 3, 0);
        expect_sig("reset_tick", 4, 0);
        reset = 1'b1;
        cyc_step(1);

        // Loads while paused: valid, out-of-range hours, out-of-range minutes, nothing adjusted.
        do_load(2'b01, 5'd10, 6'd20, 5'd0, 6'd0);
        expect_sig("load_time", 0, hms(10, 20, 0));
        do_load(2'b01, 5'd24, 6'd30, 5'd0, 6'd0);
        expect_sig("bad_hours_ignored", 0, hms(10, 20, 0));
        do_load(2'b10, 5'd0, 6'd0, 5'd5, 6'd60);
        expect_sig("bad_minutes_ignored", 1, hm(0, 0));
        do_load(2'b00, 5'd3, 6'd3, 5'd4, 6'd4);
        expect_sig("adj00_time", 0, hms(10, 20, 0));
        expect_sig("adj00_alarm", 1, hm(0, 0));
        cyc_step(10);
        expect_sig("paused_hold", 0, hms(10, 20, 0));

        // Midnight rollover.
        do_load(2'b01, 5'd23, 6'd59, 5'd0, 6'd0);
        run_en = 1'b1;
        expect_sig("tick_low_after_load", 4, 0);
        cyc_step(3);
        expect_sig("tick_pulse", 4, 1);
        expect_sig("time_before_first_tick", 0, hms(23, 59, 0));
        cyc_step(233);
        expect_sig("time_235959", 0, hms(23, 59, 59));
        cyc_step(4);
        expect_sig("time_wrap_midnight", 0, hms(0, 0, 0));

        // Load coinciding with a tick.
        cyc_step(3);
        expect_sig("tick_before_load", 4, 1);
        do_load(2'b01, 5'd12, 6'd34, 5'd0, 6'd0);
        expect_sig("load_beats_tick", 0, hms(12, 34, 0));

        // Alarm at 07:00.
        alarm_arm = 1'b1;
        cyc_step(1);
        do_load(2'b11, 5'd6, 6'd59, 5'd7, 6'd0);
        expect_sig("alarm_loaded", 1, hm(7, 0));
        expect_sig("time_0659", 0, hms(6, 59, 0));
        cyc_step(240);
        expect_sig("time_0700", 0, hms(7, 0, 0));
        expect_sig("not_yet_ringing", 2, 0);
        cyc_step(1);
        expect_sig("ringing_rises", 2, 1);
        expect_sig("led_on_first_half", 3, 1);
        cyc_step(1);
        expect_sig("led_off_second_half", 3, 0);
        cyc_step(2);
        expect_sig("led_on_next_second", 3, 1);
        expect_sig("time_070001", 0, hms(7, 0, 1));

        // Stop, no re-trigger in the same minute, re-arm once the minute has passed.
        alarm_stop = 1'b1;
        cyc_step(1);
        alarm_stop = 1'b0;
        expect_sig("stop_clears_ringing", 2, 0);
        do_load(2'b01, 5'd7, 6'd0, 5'd0, 6'd0);
        expect_sig("reload_0700", 0, hms(7, 0, 0));
        cyc_step(2);
        expect_sig("no_retrigger_silenced", 2, 0);
        cyc_step(238);
        expect_sig("time_0701", 0, hms(7, 1, 0));
        expect_sig("quiet_at_0701", 2, 0);
        cyc_step(1);
        do_load(2'b01, 5'd7, 6'd0, 5'd0, 6'd0);
        expect_sig("idle_after_reload", 2, 0);
        cyc_step(1);
        expect_sig("rearmed_rings", 2, 1);

        // Ring timeout after five seconds.
        cyc_step(18);
        expect_sig("ring_before_timeout", 2, 1);
        cyc_step(1);
        expect_sig("ring_timeout", 2, 0);
        cyc_step(8);
        expect_sig("stays_silenced", 2, 0);

        // Asynchronous reset while ringing with the clock stopped.
        do_load(2'b11, 5'd7, 6'd0, 5'd7, 6'd0);
        cyc_step(1);
        expect_sig("ring_before_reset", 2, 1);
        expect_sig("led_before_reset", 3, 1);
        @(negedge clk);
        #1;
        clk_en = 1'b0;
        #20;
        reset = 1'b0;
        #1;
        expect_sig("async_rst_ringing", 2, 0);
        expect_sig("async_rst_led", 3, 0);
        expect_sig("async_rst_tick", 4, 0);
        expect_sig("async_rst_time", 0, hms(0, 0, 0));
        expect_sig("async_rst_alarm", 1, hm(0, 0));
        ->chk_ev;
        #2;

        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, required 0", sb_q.size());
            failures = failures + sb_q.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
